// File: rtl/gerenciador_vidas.sv
// Life manager: holds remaining lives, opens an invulnerability window after each loss, flags game over.
// Latency: 1 cycle, all outputs registered. Priority: reset > reinicia > perde/ganha.
// Backpressure: none; perde/ganha are levels sampled every edge. Optional macro VIDA_EXTRA_EN enables ganha.
module gerenciador_vidas #(
    parameter int WIDTH          = 3,
    parameter int MAX_VIDAS      = 5,
    parameter int VIDAS_INICIAIS = 3,
    parameter int INVUL_CICLOS   = 4
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_perde,
    input  logic             i_ganha,
    input  logic             i_reinicia,
    output logic [WIDTH-1:0] o_vidas,
    output logic             o_game_over,
    output logic             o_invulneravel,
    output logic             o_perdeu
);

    typedef enum logic [1:0] {ATIVO, INVUL, FIM} estado_t;

    localparam logic [WIDTH-1:0] L_MAX   = WIDTH'(MAX_VIDAS);
    localparam logic [WIDTH-1:0] L_INIT  = WIDTH'(VIDAS_INICIAIS);
    localparam logic [WIDTH-1:0] L_UM    = WIDTH'(1);
    localparam logic [7:0]       L_INVUL = 8'(INVUL_CICLOS);

    estado_t          r_estado, w_estado_prox;
    logic [WIDTH-1:0] r_vidas, w_vidas_prox;
    logic [7:0]       r_cont, w_cont_prox;
    logic             r_perdeu, w_perdeu_prox;
    logic             w_ganha_eff;

`ifdef VIDA_EXTRA_EN
    assign w_ganha_eff = i_ganha;
`else
    // Extra lives disabled: the port stays for pin compatibility but is ignored.
    logic w_unused_ganha;
    assign w_unused_ganha = i_ganha;
    assign w_ganha_eff    = 1'b0;
`endif

    // State, lives, window counter and loss pulse; reset and reinicia both reload the start-of-game values.
    always_ff @(posedge i_clock) begin
        if (!i_reset || i_reinicia) begin
            r_estado <= ATIVO;
            r_vidas  <= L_INIT;
            r_cont   <= 8'd0;
            r_perdeu <= 1'b0;
        end else begin
            r_estado <= w_estado_prox;
            r_vidas  <= w_vidas_prox;
            r_cont   <= w_cont_prox;
            r_perdeu <= w_perdeu_prox;
        end
    end

    // Next-state logic: hits only count in ATIVO; extra lives apply in ATIVO and INVUL, saturating.
    always_comb begin
        w_estado_prox = r_estado;
        w_vidas_prox  = r_vidas;
        w_cont_prox   = r_cont;
        w_perdeu_prox = 1'b0;
        case (r_estado)
            ATIVO: begin
                if (i_perde && !w_ganha_eff) begin
                    w_perdeu_prox = 1'b1;
                    if (r_vidas > L_UM) begin
                        w_vidas_prox = r_vidas - L_UM;
                        if (L_INVUL != 8'd0) begin
                            w_estado_prox = INVUL;
                            w_cont_prox   = L_INVUL;
                        end
                    end else begin
                        w_vidas_prox  = '0;
                        w_estado_prox = FIM;
                    end
                end else if (w_ganha_eff && !i_perde && (r_vidas < L_MAX)) begin
                    w_vidas_prox = r_vidas + L_UM;
                end
            end
            INVUL: begin
                if (w_ganha_eff && (r_vidas < L_MAX)) begin
                    w_vidas_prox = r_vidas + L_UM;
                end
                // Counter holds the number of window cycles still to show, including this one.
                if (r_cont <= 8'd1) begin
                    w_estado_prox = ATIVO;
                    w_cont_prox   = 8'd0;
                end else begin
                    w_cont_prox = r_cont - 8'd1;
                end
            end
            FIM: begin
                w_vidas_prox = '0;
            end
            default: begin
                w_estado_prox = ATIVO;
                w_vidas_prox  = L_INIT;
                w_cont_prox   = 8'd0;
            end
        endcase
    end

    assign o_vidas        = r_vidas;
    assign o_game_over    = (r_estado == FIM);
    assign o_invulneravel = (r_estado == INVUL);
    assign o_perdeu       = r_perdeu;

endmodule

// File: tb/tb_gerenciador_vidas.sv
// Bench for gerenciador_vidas at default parameters; expected outputs queued per stimulus cycle.
// Each driven cycle pushes its expected {vidas, game_over, invulneravel, perdeu}, popped after the edge.
// Build with VIDA_EXTRA_EN defined to exercise the extra-life path instead of the ignored-ganha path.
module tb_gerenciador_vidas;

    logic       clk = 1'b0;
    logic       rst_n, perde, ganha, reinicia;
    logic [2:0] vidas;
    logic       game_over, invulneravel, perdeu;

    typedef struct packed {
        logic [2:0] v;
        logic       go;
        logic       inv;
        logic       pd;
    } saida_t;

    saida_t sb[$];
    int     n_checks = 0;
    int     n_fail   = 0;

    gerenciador_vidas #(
        .WIDTH(3), .MAX_VIDAS(5), .VIDAS_INICIAIS(3), .INVUL_CICLOS(4)
    ) dut (
        .i_clock       (clk),
        .i_reset       (rst_n),
        .i_perde       (perde),
        .i_ganha       (ganha),
        .i_reinicia    (reinicia),
        .o_vidas       (vidas),
        .o_game_over   (game_over),
        .o_invulneravel(invulneravel),
        .o_perdeu      (perdeu)
    );

    always #5 clk = ~clk;

    // Stimulus bits {perde, ganha, reinicia, reset_n}; expected result enters the scoreboard.
    task automatic drive(input logic [3:0] s, input saida_t e);
        {perde, ganha, reinicia, rst_n} = s;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [3:0] st [3];
        logic [5:0] ex [3];
        saida_t exp_v, obs;
        st = '{4'b0000, 4'b1000, 4'b0001};
        ex = '{6'b011000, 6'b011000, 6'b011000};
        for (int k = 0; k < 3; k++) begin
            drive(st[k], ex[k]);
            exp_v = sb.pop_front();
            obs = {vidas, game_over, invulneravel, perdeu};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL test_reset[%0d]: {vidas,go,inv,perdeu} got %b expected %b", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_perde;
        logic [3:0] st [6];
        logic [5:0] ex [6];
        saida_t exp_v, obs;
        st = '{4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b0001};
        ex = '{6'b010011, 6'b010010, 6'b010010, 6'b010010, 6'b010000, 6'b010000};
        for (int k = 0; k < 6; k++) begin
            drive(st[k], ex[k]);
            exp_v = sb.pop_front();
            obs = {vidas, game_over, invulneravel, perdeu};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL test_perde[%0d]: {vidas,go,inv,perdeu} got %b expected %b", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_game_over;
        logic [3:0] st [17];
        logic [5:0] ex [17];
        saida_t exp_v, obs;
        st = '{4'b0011,
               4'b1001, 4'b0001, 4'b0001, 4'b0001, 4'b0001,
               4'b1001, 4'b0001, 4'b0001, 4'b0001, 4'b0001,
               4'b1001, 4'b1001, 4'b0101, 4'b1101,
               4'b0011, 4'b1011};
        ex = '{6'b011000,
               6'b010011, 6'b010010, 6'b010010, 6'b010010, 6'b010000,
               6'b001011, 6'b001010, 6'b001010, 6'b001010, 6'b001000,
               6'b000101, 6'b000100, 6'b000100, 6'b000100,
               6'b011000, 6'b011000};
        for (int k = 0; k < 17; k++) begin
            drive(st[k], ex[k]);
            exp_v = sb.pop_front();
            obs = {vidas, game_over, invulneravel, perdeu};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL test_game_over[%0d]: {vidas,go,inv,perdeu} got %b expected %b", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_ganha;
        logic [3:0] st [6];
        logic [5:0] ex [6];
        saida_t exp_v, obs;
`ifdef VIDA_EXTRA_EN
        st = '{4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b1101, 4'b0011};
        ex = '{6'b100000, 6'b101000, 6'b101000, 6'b101000, 6'b101000, 6'b011000};
`else
        // ganha is ignored, so perde together with ganha is an ordinary hit.
        st = '{4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b1101, 4'b0011};
        ex = '{6'b011000, 6'b011000, 6'b011000, 6'b011000, 6'b010011, 6'b011000};
`endif
        for (int k = 0; k < 6; k++) begin
            drive(st[k], ex[k]);
            exp_v = sb.pop_front();
            obs = {vidas, game_over, invulneravel, perdeu};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL test_ganha[%0d]: {vidas,go,inv,perdeu} got %b expected %b", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_abort_invul;
        logic [3:0] st [7];
        logic [5:0] ex [7];
        saida_t exp_v, obs;
        // Reset lands on the 2nd window cycle; later reinicia aborts a fresh window.
        st = '{4'b1001, 4'b0001, 4'b0000, 4'b0001, 4'b1001, 4'b0011, 4'b0001};
        ex = '{6'b010011, 6'b010010, 6'b011000, 6'b011000, 6'b010011, 6'b011000, 6'b011000};
        for (int k = 0; k < 7; k++) begin
            drive(st[k], ex[k]);
            exp_v = sb.pop_front();
            obs = {vidas, game_over, invulneravel, perdeu};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL test_abort_invul[%0d]: {vidas,go,inv,perdeu} got %b expected %b", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] st [13];
        logic [5:0] ex [13];
        saida_t exp_v, obs;
        // perde held continuously: one loss per window plus the first ATIVO edge after it.
        st = '{4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b1001,
               4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b1001,
               4'b1001, 4'b1001, 4'b0011};
        ex = '{6'b010011, 6'b010010, 6'b010010, 6'b010010, 6'b010000,
               6'b001011, 6'b001010, 6'b001010, 6'b001010, 6'b001000,
               6'b000101, 6'b000100, 6'b011000};
        for (int k = 0; k < 13; k++) begin
            drive(st[k], ex[k]);
            exp_v = sb.pop_front();
            obs = {vidas, game_over, invulneravel, perdeu};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL test_back_to_back[%0d]: {vidas,go,inv,perdeu} got %b expected %b", k, obs, exp_v);
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        perde    = 1'b0;
        ganha    = 1'b0;
        reinicia = 1'b0;
        test_reset();
        test_perde();
        test_game_over();
        test_ganha();
        test_abort_invul();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
